// File: rtl/decode_stage.sv
// ID stage of the 5-stage MIPS pipeline: IF/ID register, 32x32 register file
// with write-through bypass, sign extension and load-use hazard detection.
module decode_stage #(
    parameter int          REG_COUNT = 32,
    parameter logic [31:0] NOP_WORD  = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inAdder,
    input  logic [31:0] inInstruction,
    input  logic        inStall,
    input  logic        inFlush,
    input  logic        inWbEn,
    input  logic [4:0]  inWbAddr,
    input  logic [31:0] inWbData,
    input  logic        inExMemRead,
    input  logic [4:0]  inExRt,
    output logic [31:0] outAdder,
    output logic [31:0] outRD1,
    output logic [31:0] outRD2,
    output logic [31:0] outSignExt,
    output logic [4:0]  outInsA,
    output logic [4:0]  outInsB,
    output logic        outValid,
    output logic        outHazard
);

    logic [31:0] pc_reg;
    logic [31:0] instr_reg;
    logic        valid_reg;
    logic [31:0] rf_reg [REG_COUNT];

    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        wb_active;
    logic        hazard;

    assign rs        = instr_reg[25:21];
    assign rt        = instr_reg[20:16];
    assign wb_active = inWbEn && (inWbAddr != 5'd0);

    // Load-use: the instruction in ID reads the register a load in EX is about to produce.
    assign hazard = valid_reg && inExMemRead && (inExRt != 5'd0) &&
                    ((inExRt == rs) || (inExRt == rt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg    <= 32'h0;
            instr_reg <= NOP_WORD;
            valid_reg <= 1'b0;
        end else if (inFlush) begin
            pc_reg    <= 32'h0;
            instr_reg <= NOP_WORD;
            valid_reg <= 1'b0;
        end else if (!(inStall || hazard)) begin
            pc_reg    <= inAdder;
            instr_reg <= inInstruction;
            valid_reg <= 1'b1;
        end
    end

    // Register 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                rf_reg[i] <= 32'h0;
            end
        end else if (wb_active) begin
            rf_reg[inWbAddr] <= inWbData;
        end
    end

    always_comb begin
        outRD1 = rf_reg[rs];
        if (rs == 5'd0) begin
            outRD1 = 32'h0;
        end else if (wb_active && (inWbAddr == rs)) begin
            outRD1 = inWbData;
        end
    end

    always_comb begin
        outRD2 = rf_reg[rt];
        if (rt == 5'd0) begin
            outRD2 = 32'h0;
        end else if (wb_active && (inWbAddr == rt)) begin
            outRD2 = inWbData;
        end
    end

    assign outAdder   = pc_reg;
    assign outSignExt = {{16{instr_reg[15]}}, instr_reg[15:0]};
    assign outInsA    = instr_reg[20:16];
    assign outInsB    = instr_reg[15:11];
    assign outValid   = valid_reg;
    assign outHazard  = hazard;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table, reset sequence,
// then randomized traffic checked against a behavioural model.
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] inAdder;
    logic [31:0] inInstruction;
    logic        inStall;
    logic        inFlush;
    logic        inWbEn;
    logic [4:0]  inWbAddr;
    logic [31:0] inWbData;
    logic        inExMemRead;
    logic [4:0]  inExRt;
    logic [31:0] outAdder;
    logic [31:0] outRD1;
    logic [31:0] outRD2;
    logic [31:0] outSignExt;
    logic [4:0]  outInsA;
    logic [4:0]  outInsB;
    logic        outValid;
    logic        outHazard;

    decode_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .inAdder       (inAdder),
        .inInstruction (inInstruction),
        .inStall       (inStall),
        .inFlush       (inFlush),
        .inWbEn        (inWbEn),
        .inWbAddr      (inWbAddr),
        .inWbData      (inWbData),
        .inExMemRead   (inExMemRead),
        .inExRt        (inExRt),
        .outAdder      (outAdder),
        .outRD1        (outRD1),
        .outRD2        (outRD2),
        .outSignExt    (outSignExt),
        .outInsA       (outInsA),
        .outInsB       (outInsB),
        .outValid      (outValid),
        .outHazard     (outHazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model: architectural state as plain arrays/variables.
    logic [31:0] m_rf [32];
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_valid;

    typedef struct {
        logic [31:0] adder;
        logic [31:0] instr;
        logic        stall;
        logic        flush;
        logic        wben;
        logic [4:0]  wbaddr;
        logic [31:0] wbdata;
        logic        exmr;
        logic [4:0]  exrt;
        logic [31:0] e_adder;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_sext;
        logic [4:0]  e_insa;
        logic [4:0]  e_insb;
        logic        e_valid;
        logic        e_haz;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        m_pc    = 32'h0;
        m_instr = 32'h0;
        m_valid = 1'b0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (inWbEn && inWbAddr == idx) return inWbData;
        return m_rf[idx];
    endfunction

    function automatic logic m_hazard();
        logic [4:0] rs;
        logic [4:0] rt;
        rs = m_instr[25:21];
        rt = m_instr[20:16];
        return m_valid && inExMemRead && inExRt != 5'd0 && (inExRt == rs || inExRt == rt);
    endfunction

    task automatic drive(input logic [31:0] adder, input logic [31:0] instr,
                         input logic stall, input logic flush, input logic wben,
                         input logic [4:0] wbaddr, input logic [31:0] wbdata,
                         input logic exmr, input logic [4:0] exrt);
        inAdder       = adder;
        inInstruction = instr;
        inStall       = stall;
        inFlush       = flush;
        inWbEn        = wben;
        inWbAddr      = wbaddr;
        inWbData      = wbdata;
        inExMemRead   = exmr;
        inExRt        = exrt;
        @(negedge clk);
    endtask

    // Advance over the rising edge, stepping the model with the inputs seen there.
    task automatic finish_cycle();
        logic haz;
        @(posedge clk);
        haz = m_hazard();
        if (inWbEn && inWbAddr != 5'd0) m_rf[inWbAddr] = inWbData;
        if (inFlush) begin
            m_pc = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
        end else if (!(inStall || haz)) begin
            m_pc = inAdder; m_instr = inInstruction; m_valid = 1'b1;
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " adder"},  outAdder,   m_pc);
        chk({tag, " rd1"},    outRD1,     m_read(m_instr[25:21]));
        chk({tag, " rd2"},    outRD2,     m_read(m_instr[20:16]));
        chk({tag, " sext"},   outSignExt, {{16{m_instr[15]}}, m_instr[15:0]});
        chk({tag, " insA"},   32'(outInsA), 32'(m_instr[20:16]));
        chk({tag, " insB"},   32'(outInsB), 32'(m_instr[15:11]));
        chk({tag, " valid"},  32'(outValid), 32'(m_valid));
        chk({tag, " hazard"}, 32'(outHazard), 32'(m_hazard()));
    endtask

    initial begin
        tbl[0]  = '{32'h4,  32'h00000000, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0,
                    32'h0,  32'h0,        32'h0, 32'h0,        5'd0, 5'd0,  1'b0, 1'b0};
        tbl[1]  = '{32'h8,  32'h00A00000, 1'b0, 1'b0, 1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0,
                    32'h4,  32'h0,        32'h0, 32'h0,        5'd0, 5'd0,  1'b1, 1'b0};
        tbl[2]  = '{32'hC,  32'h00000000, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0,
                    32'h8,  32'hDEADBEEF, 32'h0, 32'h0,        5'd0, 5'd0,  1'b1, 1'b0};
        tbl[3]  = '{32'h10, 32'h00E00000, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0,
                    32'hC,  32'h0,        32'h0, 32'h0,        5'd0, 5'd0,  1'b1, 1'b0};
        tbl[4]  = '{32'h40, 32'h8CA8FFFC, 1'b0, 1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0,
                    32'h10, 32'hA5A5A5A5, 32'h0, 32'h0,        5'd0, 5'd0,  1'b1, 1'b0};
        tbl[5]  = '{32'h44, 32'h20027FFF, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd8,
                    32'h40, 32'hDEADBEEF, 32'h0, 32'hFFFFFFFC, 5'd8, 5'd31, 1'b1, 1'b1};
        tbl[6]  = '{32'h44, 32'h20027FFF, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd0,
                    32'h40, 32'hDEADBEEF, 32'h0, 32'hFFFFFFFC, 5'd8, 5'd31, 1'b1, 1'b0};
        tbl[7]  = '{32'h48, 32'h00E00000, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 5'd2,
                    32'h44, 32'h0,        32'h0, 32'h00007FFF, 5'd2, 5'd15, 1'b1, 1'b1};
        tbl[8]  = '{32'h48, 32'h00E00000, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd2,
                    32'h0,  32'h0,        32'h0, 32'h0,        5'd0, 5'd0,  1'b0, 1'b0};
        for (int i = 9; i < 12; i++)
            tbl[i] = '{32'h4C, 32'h00A00000, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                       32'h48, 32'hA5A5A5A5, 32'h0, 32'h0, 5'd0, 5'd0, 1'b1, 1'b0};
        tbl[12] = '{32'h4C, 32'h00A00000, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0,
                    32'h48, 32'hA5A5A5A5, 32'h0, 32'h0,        5'd0, 5'd0,  1'b1, 1'b0};
        tbl[13] = '{32'h50, 32'h00000000, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0,
                    32'h4C, 32'hDEADBEEF, 32'h0, 32'h0,        5'd0, 5'd0,  1'b1, 1'b0};

        rst_n = 1'b0;
        inAdder = 32'h0; inInstruction = 32'h0; inStall = 1'b0; inFlush = 1'b0;
        inWbEn = 1'b0; inWbAddr = 5'd0; inWbData = 32'h0; inExMemRead = 1'b0; inExRt = 5'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed table: expected values are the combinational outputs before each edge.
        for (int i = 0; i < 14; i++) begin
            drive(tbl[i].adder, tbl[i].instr, tbl[i].stall, tbl[i].flush, tbl[i].wben,
                  tbl[i].wbaddr, tbl[i].wbdata, tbl[i].exmr, tbl[i].exrt);
            chk($sformatf("vec%0d adder", i),  outAdder,   tbl[i].e_adder);
            chk($sformatf("vec%0d rd1", i),    outRD1,     tbl[i].e_rd1);
            chk($sformatf("vec%0d rd2", i),    outRD2,     tbl[i].e_rd2);
            chk($sformatf("vec%0d sext", i),   outSignExt, tbl[i].e_sext);
            chk($sformatf("vec%0d insA", i),   32'(outInsA),   32'(tbl[i].e_insa));
            chk($sformatf("vec%0d insB", i),   32'(outInsB),   32'(tbl[i].e_insb));
            chk($sformatf("vec%0d valid", i),  32'(outValid),  32'(tbl[i].e_valid));
            chk($sformatf("vec%0d hazard", i), 32'(outHazard), 32'(tbl[i].e_haz));
            $display("vec %0d: adder=%h rd1=%h rd2=%h sext=%h valid=%0b haz=%0b",
                     i, outAdder, outRD1, outRD2, outSignExt, outValid, outHazard);
            finish_cycle();
        end

        // Asynchronous reset mid-stream with IF/ID loaded.
        inWbEn = 1'b0; inStall = 1'b0; inFlush = 1'b0; inExMemRead = 1'b1; inExRt = 5'd5;
        inInstruction = 32'h00A70000;
        rst_n = 1'b0;
        #1;
        chk("rst adder",  outAdder,   32'h0);
        chk("rst rd1",    outRD1,     32'h0);
        chk("rst rd2",    outRD2,     32'h0);
        chk("rst sext",   outSignExt, 32'h0);
        chk("rst insA",   32'(outInsA), 32'h0);
        chk("rst insB",   32'(outInsB), 32'h0);
        chk("rst valid",  32'(outValid), 32'h0);
        chk("rst hazard", 32'(outHazard), 32'h0);
        $display("reset: adder=%h rd1=%h valid=%0b haz=%0b", outAdder, outRD1, outValid, outHazard);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(32'h4, 32'h00A70000, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        finish_cycle();
        drive(32'h8, 32'h00000000, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        chk("post-rst r5", outRD1, 32'h0);
        chk("post-rst r7", outRD2, 32'h0);
        chk("post-rst valid", 32'(outValid), 32'h1);
        $display("post-reset read: rd1=%h rd2=%h", outRD1, outRD2);
        finish_cycle();

        // Randomized traffic, register indices biased low to exercise bypass and hazards.
        for (int n = 0; n < 300; n++) begin
            logic [31:0] instr;
            instr = $urandom;
            instr[25:21] = 5'($urandom_range(0, 7));
            instr[20:16] = 5'($urandom_range(0, 7));
            drive($urandom, instr, ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 1) == 0), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)));
            check_model($sformatf("rand%0d", n));
            $display("rand %0d: instr=%h adder=%h rd1=%h rd2=%h valid=%0b haz=%0b",
                     n, m_instr, outAdder, outRD1, outRD2, outValid, outHazard);
            finish_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the 5-stage MIPS pipeline; sits directly upstream of the ID/EX buffer and drives all of that buffer's inputs.
- Contains the IF/ID pipeline register with stall/flush, the 32x32 register file with writeback port and write-through bypass, the sign extender, and load-use hazard detection.
- Its outputs are combinational from the IF/ID register and register file; the ID/EX buffer registers them on the next edge.

Parameters:
- REG_COUNT, 32, number of architectural registers; register 0 is hard-wired zero.
- NOP_WORD, 32'h00000000, instruction word loaded into IF/ID on flush and reset.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- inAdder  input  32  PC+4 from fetch.
- inInstruction  input  32  fetched instruction word.
- inStall  input  1  external stall; hold IF/ID.
- inFlush  input  1  branch/jump flush; load NOP into IF/ID.
- inWbEn  input  1  register-file write enable from WB.
- inWbAddr  input  5  writeback register index.
- inWbData  input  32  writeback data.
- inExMemRead  input  1  instruction currently in EX is a load.
- inExRt  input  5  destination (rt) of instruction in EX.
- outAdder  output  32  held PC+4.
- outRD1  output  32  register value at rs (instr[25:21]).
- outRD2  output  32  register value at rt (instr[20:16]).
- outSignExt  output  32  sign-extended instr[15:0].
- outInsA  output  5  rt field, instr[20:16].
- outInsB  output  5  rd field, instr[15:11].
- outValid  output  1  IF/ID holds a real (non-flushed) instruction.
- outHazard  output  1  load-use stall request to fetch and ID/EX control.

Behaviour:
- Reset (rst_n=0, asynchronous): IF/ID PC and instruction = 0 (NOP_WORD), valid = 0, all registers = 0. All outputs therefore read 0, outHazard = 0. Reset asserted mid-operation discards in-flight instruction and all register contents immediately.
- IF/ID update, at rising edge, priority order:
  - inFlush=1: instruction <= NOP_WORD, PC <= 0, valid <= 0. Flush wins over stall and hazard.
  - inStall=1 or outHazard=1: hold all IF/ID contents.
  - Otherwise: capture inAdder and inInstruction, valid <= 1.
- Register file:
  - Write at rising edge when inWbEn=1 and inWbAddr!=0.
  - Writes to index 0 are ignored; reads of index 0 always return 0.
  - Writes are independent of stall/flush.
- Reads are combinational from the IF/ID instruction fields, with write-through bypass: if inWbEn=1, inWbAddr!=0 and inWbAddr equals the read index, output inWbData instead of the stored value. The bypass applies to rs and rt independently and gives same-cycle WB-to-ID forwarding.
- Sign extension: outSignExt = {16{instr[15]}, instr[15:0]}.
- outInsA = instr[20:16]; outInsB = instr[15:11]; outAdder = IF/ID PC.
- Hazard: outHazard = valid and inExMemRead and inExRt!=0 and (inExRt==rs or inExRt==rt); purely combinational. The consumer inserts the bubble into ID/EX; this block only holds IF/ID.
- Latency: an instruction captured at edge N has decoded outputs valid after edge N, and is registered by the ID/EX buffer at edge N+1.

Test Plan:
- Reset: drive rst_n=0 mid-stream with IF/ID loaded -> all outputs 0 immediately (no clock), outValid=0, outHazard=0; after release, reading any register -> 0.
- Write/read: WB writes r5=32'hDEADBEEF; next cycle fetch instr with rs=5, rt=0 -> outRD1=32'hDEADBEEF, outRD2=0; a WB write to r0 of 32'h1234 -> r0 still reads 0.
- Bypass: IF/ID holds rs=7 while inWbEn=1, inWbAddr=7, inWbData=32'hA5A5A5A5 in the same cycle -> outRD1=32'hA5A5A5A5 before the edge.
- Sign extension and fields: instr=32'h8C a8 FFFC (lw, rt=8, imm=-4) with inAdder=32'h40 -> outSignExt=32'hFFFFFFFC, outInsA=8, outAdder=32'h40; imm 16'h7FFF -> 32'h00007FFF.
- Load-use: IF/ID rs=3, inExMemRead=1, inExRt=3 -> outHazard=1 and IF/ID holds over the edge; inExRt=0 or inExMemRead=0 -> outHazard=0 and capture proceeds.
- Flush vs stall: inFlush=1 and inStall=1 together -> IF/ID = NOP, outValid=0, outHazard=0 next cycle; inStall=1 alone for 3 cycles -> outputs unchanged, then next fetch captured on release.
